// File: rtl/gpu_mem_port_mux.sv
// Burst-aware multiplexer funnelling N requester channels onto one memory port.
// The port is locked to the granted requester until its last beat; read responses route back via a tag FIFO.
module gpu_mem_port_mux #(
  parameter int unsigned NUM_REQUESTERS  = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQUESTERS-1:0]            i_req_valid,
  input  logic [NUM_REQUESTERS*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_REQUESTERS*DATA_W-1:0]     i_req_wdata,
  input  logic [NUM_REQUESTERS-1:0]            i_req_we,
  input  logic [NUM_REQUESTERS-1:0]            i_req_last,
  output logic [NUM_REQUESTERS-1:0]            o_req_ready,
  output logic [NUM_REQUESTERS-1:0]            o_arb_requests,
  input  logic [NUM_REQUESTERS-1:0]            i_arb_grants,
  output logic                                 o_mem_valid,
  output logic                                 o_mem_we,
  output logic                                 o_mem_last,
  output logic [ADDR_W-1:0]                    o_mem_addr,
  output logic [DATA_W-1:0]                    o_mem_wdata,
  input  logic                                 i_mem_ready,
  input  logic                                 i_mem_rvalid,
  input  logic [DATA_W-1:0]                    i_mem_rdata,
  output logic [NUM_REQUESTERS-1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]                    o_rsp_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
  output logic                                 o_err_orphan
);

  localparam int unsigned IDXW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     grant_idx;
  logic [IDXW-1:0]     sel_idx;
  logic                sel_vld;

  logic                s_hit, s_valid, s_we, s_last;
  logic [ADDR_W-1:0]   s_addr;
  logic [DATA_W-1:0]   s_wdata;
  logic                blk, accept;

  logic [IDXW-1:0]     fifo_q [MAX_OUTSTANDING];
  logic [PTRW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                fifo_full, fifo_empty, push, pop;
  logic [IDXW-1:0]     head;

  logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_data_q;
  logic                      orphan_q;

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (i_arb_grants[i]) grant_idx = IDXW'(i);
    end
  end

  always_comb begin
    if (state_q == S_LOCK) begin
      sel_vld = 1'b1;
      sel_idx = owner_q;
    end else begin
      sel_vld = |i_arb_grants;
      sel_idx = grant_idx;
    end
  end

  always_comb begin
    s_hit   = 1'b0;
    s_valid = 1'b0;
    s_we    = 1'b0;
    s_last  = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (sel_vld && (sel_idx == IDXW'(i))) begin
        s_hit   = 1'b1;
        s_valid = i_req_valid[i];
        s_we    = i_req_we[i];
        s_last  = i_req_last[i];
        s_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        s_wdata = i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered full flag: a same-cycle pop cannot free a slot for this beat.
  assign blk         = s_hit && !s_we && fifo_full;
  assign o_mem_valid = s_valid && !blk;
  assign o_mem_we    = s_we;
  assign o_mem_last  = s_last;
  assign o_mem_addr  = s_addr;
  assign o_mem_wdata = s_wdata;
  assign accept      = o_mem_valid && i_mem_ready;

  always_comb begin
    o_req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      o_req_ready[i] = s_hit && (sel_idx == IDXW'(i)) && i_mem_ready && !blk;
    end
  end

  assign o_arb_requests = (state_q == S_IDLE) ? i_req_valid : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if ((|i_arb_grants) && !(accept && s_last)) begin
          state_d = S_LOCK;
          owner_d = grant_idx;
        end
      end
      S_LOCK: begin
        if (accept && s_last) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign fifo_full  = (cnt_q == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign push       = accept && !s_we;
  assign pop        = i_mem_rvalid && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= sel_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (pop && (head == IDXW'(i))) rsp_valid_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (pop) rsp_data_q <= i_mem_rdata;
      if (i_mem_rvalid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_outstanding = cnt_q;
  assign o_err_orphan  = orphan_q;

endmodule
